// File: rtl/rr_mux_reg.sv
// N:1 datapath mux with round-robin arbitration and one registered output stage.
// Optional MUX_FORCE_SEL_EN adds force_en/force_sel to bypass the arbiter.
module rr_mux_reg #(
  parameter  int WIDTH  = 16,
  parameter  int NUM_IN = 8,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_chan,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef MUX_FORCE_SEL_EN
  ,
  input  logic                    force_en,
  input  logic [SEL_W-1:0]        force_sel
`endif
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load;
  logic             rr_found;
  logic [SEL_W-1:0] rr_grant;
  logic             found;
  logic [SEL_W-1:0] grant;
  logic             advance;
  logic [WIDTH-1:0] sel_data;

  assign load = !valid_q || out_ready;

  // Circular scan starting at ptr_q; first valid channel wins.
  always_comb begin
    int unsigned idx;
    rr_found = 1'b0;
    rr_grant = '0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!rr_found && in_valid[idx]) begin
        rr_found = 1'b1;
        rr_grant = SEL_W'(idx);
      end
    end
  end

`ifdef MUX_FORCE_SEL_EN
  always_comb begin
    logic force_hit;
    force_hit = 1'b0;
    if (32'(force_sel) < NUM_IN) force_hit = in_valid[force_sel];
    found   = force_en ? force_hit : rr_found;
    grant   = force_en ? force_sel : rr_grant;
    advance = !force_en;
  end
`else
  always_comb begin
    found   = rr_found;
    grant   = rr_grant;
    advance = 1'b1;
  end
`endif

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (grant == SEL_W'(i)) begin
        in_ready[i] = load && found;
        sel_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (found) begin
        data_d  = sel_data;
        chan_d  = grant;
        valid_d = 1'b1;
        if (advance) ptr_d = (grant == SEL_W'(NUM_IN - 1)) ? '0 : grant + SEL_W'(1);
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Self-checking bench for rr_mux_reg against a queue-free behavioural round-robin model.
module tb_rr_mux_reg;
  localparam int W = 16;
`ifdef MUX_FORCE_SEL_EN
  localparam int N = 5;
`else
  localparam int N = 8;
`endif
  localparam int SW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_chan;
  logic            out_valid;
  logic            out_ready;
  logic            force_en;
  logic [SW-1:0]   force_sel;

  int n_checks = 0;
  int n_fail   = 0;

  int           m_ptr;
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_chan;
  logic         e_load, e_found;
  int           e_grant;
  logic [N-1:0] exp_ready, obs_ready;

  always #5 clk = ~clk;

  rr_mux_reg #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_chan(out_chan),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef MUX_FORCE_SEL_EN
    ,
    .force_en(force_en),
    .force_sel(force_sel)
`endif
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_chan = 0;
  endtask

  task automatic model_comb();
    e_load  = !m_valid || out_ready;
    e_found = 1'b0;
    e_grant = 0;
    if (force_en) begin
      if (int'(force_sel) < N && in_valid[force_sel]) begin
        e_found = 1'b1; e_grant = int'(force_sel);
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!e_found && in_valid[(m_ptr + k) % N]) begin
          e_found = 1'b1; e_grant = (m_ptr + k) % N;
        end
      end
    end
    exp_ready = '0;
    if (e_load && e_found) exp_ready[e_grant] = 1'b1;
  endtask

  task automatic model_seq();
    if (e_load) begin
      if (e_found) begin
        m_data  = in_data[e_grant*W +: W];
        m_chan  = e_grant;
        m_valid = 1'b1;
        if (!force_en) m_ptr = (e_grant + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  // One clock: model evaluated before the edge, outputs settle #1 after it.
  task automatic tick();
    @(negedge clk);
    model_comb();
    obs_ready = in_ready;
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic fill_random_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_chan !== '0) begin
      n_fail++;
      $display("FAIL reset_init: got v=%b d=%h c=%0d expected 0/0/0", out_valid, out_data, out_chan);
    end
    rst_n = 1'b1;
    model_reset();
    fill_random_data();
    in_valid = '1;
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      n_checks++;
      if (out_valid !== m_valid || out_data !== m_data || out_chan !== SW'(m_chan) || obs_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL reset_stream: got v=%b d=%h c=%0d r=%b expected v=%b d=%h c=%0d r=%b",
                 out_valid, out_data, out_chan, obs_ready, m_valid, m_data, m_chan, exp_ready);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_chan !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got v=%b d=%h c=%0d expected 0/0/0", out_valid, out_data, out_chan);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_chan !== '0 || out_data !== in_data[W-1:0]) begin
      n_fail++;
      $display("FAIL reset_first_grant: got v=%b c=%0d d=%h expected 1/0/%h", out_valid, out_chan, out_data, in_data[W-1:0]);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(16'h1000 + i);
    in_valid = '1;
    out_ready = 1'b1;
    for (int c = 0; c <= N; c++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_chan !== SW'(c % N) || out_data !== W'(16'h1000 + c % N)
          || obs_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL round_robin[%0d]: got v=%b c=%0d d=%h r=%b expected v=1 c=%0d d=%h r=%b",
                 c, out_valid, out_chan, out_data, obs_ready, c % N, 16'h1000 + c % N, exp_ready);
      end
    end
  endtask

  task automatic test_skip_wrap();
    int exp_seq [3];
    exp_seq = '{1, N - 1, 1};
    do_reset();
    fill_random_data();
    out_ready = 1'b1;
    in_valid = '0;
    in_valid[1] = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      if (s == 0) in_valid[N-1] = 1'b1;
      n_checks++;
      if (out_valid !== 1'b1 || out_chan !== SW'(exp_seq[s]) || out_data !== m_data || obs_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL skip_wrap[%0d]: got v=%b c=%0d d=%h r=%b expected v=1 c=%0d d=%h r=%b",
                 s, out_valid, out_chan, out_data, obs_ready, exp_seq[s], m_data, exp_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0]  held_d;
    logic [SW-1:0] held_c;
    do_reset();
    fill_random_data();
    in_valid = '1;
    out_ready = 1'b1;
    tick();
    held_d = out_data;
    held_c = out_chan;
    out_ready = 1'b0;
    repeat (3) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== held_d || out_chan !== held_c || obs_ready !== '0) begin
        n_fail++;
        $display("FAIL backpressure_hold: got v=%b d=%h c=%0d r=%b expected v=1 d=%h c=%0d r=0",
                 out_valid, out_data, out_chan, obs_ready, held_d, held_c);
      end
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_chan !== SW'((int'(held_c) + 1) % N) || out_data !== m_data) begin
      n_fail++;
      $display("FAIL backpressure_release: got v=%b c=%0d d=%h expected v=1 c=%0d d=%h",
               out_valid, out_chan, out_data, (int'(held_c) + 1) % N, m_data);
    end
  endtask

  task automatic test_idle();
    int last_c;
    last_c = int'(out_chan);
    in_valid = '0;
    out_ready = 1'b1;
    repeat (2) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || obs_ready !== '0) begin
        n_fail++;
        $display("FAIL idle: got v=%b r=%b expected v=0 r=0", out_valid, obs_ready);
      end
    end
    in_valid = '1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_chan !== SW'((last_c + 1) % N)) begin
      n_fail++;
      $display("FAIL idle_ptr_hold: got v=%b c=%0d expected v=1 c=%0d", out_valid, out_chan, (last_c + 1) % N);
    end
  endtask

`ifdef MUX_FORCE_SEL_EN
  task automatic test_force();
    do_reset();
    fill_random_data();
    in_valid = '1;
    out_ready = 1'b1;
    force_en = 1'b0;
    tick();
    force_en = 1'b1;
    force_sel = SW'(3);
    repeat (4) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_chan !== SW'(3) || out_data !== in_data[3*W +: W] || obs_ready !== N'(1 << 3)) begin
        n_fail++;
        $display("FAIL force_sel3: got v=%b c=%0d d=%h r=%b expected v=1 c=3 d=%h r=%b",
                 out_valid, out_chan, out_data, obs_ready, in_data[3*W +: W], N'(1 << 3));
      end
    end
    force_sel = SW'(6);
    tick();
    n_checks++;
    if (obs_ready !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL force_out_of_range: got r=%b v=%b expected r=0 v=0", obs_ready, out_valid);
    end
    force_en = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_chan !== SW'(1)) begin
      n_fail++;
      $display("FAIL force_resume: got v=%b c=%0d expected v=1 c=1", out_valid, out_chan);
    end
  endtask
`endif

  task automatic test_random();
    int waits [N];
    int max_wait;
    max_wait = 0;
    do_reset();
    fill_random_data();
    for (int i = 0; i < N; i++) waits[i] = 0;
    in_valid = N'($urandom);
    for (int cyc = 0; cyc < 400; cyc++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      n_checks++;
      if (out_valid !== m_valid || out_data !== m_data || out_chan !== SW'(m_chan) || obs_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%b d=%h c=%0d r=%b expected v=%b d=%h c=%0d r=%b",
                 cyc, out_valid, out_data, out_chan, obs_ready, m_valid, m_data, m_chan, exp_ready);
      end
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i] || exp_ready[i]) waits[i] = 0;
        else if (e_load && e_found) waits[i]++;
        if (waits[i] > max_wait) max_wait = waits[i];
        if (exp_ready[i] || !in_valid[i]) begin
          in_valid[i] = ($urandom_range(0, 3) != 0);
          in_data[i*W +: W] = W'($urandom);
        end
      end
    end
    n_checks++;
    if (max_wait > N - 1) begin
      n_fail++;
      $display("FAIL fairness: got max wait %0d transfers expected at most %0d", max_wait, N - 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_data = '0;
    in_valid = '0;
    out_ready = 1'b0;
    force_en = 1'b0;
    force_sel = '0;
    model_reset();
    test_reset();
    test_round_robin();
    test_skip_wrap();
    test_backpressure();
    test_idle();
`ifdef MUX_FORCE_SEL_EN
    test_force();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
